// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_pkg
// Brief   : Shared opcode/state encodings and helpers for the HI/LO engine.
// Revision: 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam int MD_ITERS = 32;

    function automatic logic isSignedOp(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic isDivOp(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_if
// Brief   : Execute-stage request / HI-LO result bundle for muldiv_unit.
// Revision: 1.0 - initial release
// ============================================================================
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             startE;
    muldiv_op_t       opE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             hiwriteE;
    logic             lowriteE;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output startE, opE, srcaE, srcbE, hiwriteE, lowriteE,
        input  busy, done, hi, lo
    );

    modport slave (
        input  startE, opE, srcaE, srcbE, hiwriteE, lowriteE,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_step
// Brief   : One radix-2 iteration: shift-add multiply or restoring divide.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             divMode,
    input  logic [WIDTH-1:0] accIn,
    input  logic [WIDTH-1:0] opndIn,
    input  logic [WIDTH-1:0] magIn,
    output logic [WIDTH-1:0] accOut,
    output logic [WIDTH-1:0] opndOut
);
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shRem;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    always_comb begin
        w_sum   = {1'b0, accIn} + (opndIn[0] ? {1'b0, magIn} : '0);
        w_shRem = {accIn, opndIn[WIDTH-1]};
        // Low bits of the difference are exact whenever the subtract is kept.
        w_diff  = w_shRem[WIDTH-1:0] - magIn;
        w_ge    = (w_shRem >= {1'b0, magIn});
        if (divMode) begin
            accOut  = w_ge ? w_diff : w_shRem[WIDTH-1:0];
            opndOut = {opndIn[WIDTH-2:0], w_ge};
        end else begin
            accOut  = w_sum[WIDTH:1];
            opndOut = {w_sum[0], opndIn[WIDTH-1:1]};
        end
    end
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit
// Brief   : 32-iteration multiply/divide engine owning the HI/LO registers.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    md_state_t        r_state;
    md_state_t        w_stateNext;
    logic [CNTW-1:0]  r_cnt;
    logic             r_isDiv;
    logic             r_negRes;
    logic             r_negRem;
    logic             r_divZero;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] r_origA;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    logic             w_lastIter;
    logic             w_aNeg;
    logic             w_bNeg;
    logic [WIDTH-1:0] w_aMag;
    logic [WIDTH-1:0] w_bMag;
    logic [WIDTH-1:0] w_accNext;
    logic [WIDTH-1:0] w_opndNext;
    logic [2*WIDTH-1:0] w_mulRes;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_hiRes;
    logic [WIDTH-1:0] w_loRes;

    assign w_lastIter = (r_cnt == CNTW'(MD_ITERS - 1));

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .divMode (r_isDiv),
        .accIn   (r_acc),
        .opndIn  (r_opnd),
        .magIn   (r_mag),
        .accOut  (w_accNext),
        .opndOut (w_opndNext)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= MD_IDLE;
        else       r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            MD_IDLE: if (bus.startE) w_stateNext = MD_RUN;
            MD_RUN:  if (w_lastIter) w_stateNext = MD_DONE;
            MD_DONE: w_stateNext = MD_IDLE;
            default: w_stateNext = MD_IDLE;
        endcase
    end

    // 0x8000_0000 negates to itself, which is exactly 2^31 read as unsigned.
    always_comb begin
        w_aNeg = isSignedOp(bus.opE) & bus.srcaE[WIDTH-1];
        w_bNeg = isSignedOp(bus.opE) & bus.srcbE[WIDTH-1];
        w_aMag = w_aNeg ? -bus.srcaE : bus.srcaE;
        w_bMag = w_bNeg ? -bus.srcbE : bus.srcbE;
    end

    always_comb begin
        w_mulRes = {w_accNext, w_opndNext};
        if (r_negRes) w_mulRes = -w_mulRes;
        w_quot = r_negRes ? -w_opndNext : w_opndNext;
        w_rem  = r_negRem ? -w_accNext  : w_accNext;
        w_hiRes = w_mulRes[2*WIDTH-1:WIDTH];
        w_loRes = w_mulRes[WIDTH-1:0];
        if (r_isDiv) begin
            if (r_divZero) begin
                w_hiRes = r_origA;
                w_loRes = '1;
            end else begin
                w_hiRes = w_rem;
                w_loRes = w_quot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_mag     <= '0;
            r_origA   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_busy <= (w_stateNext != MD_IDLE);
            r_done <= (w_stateNext == MD_DONE);
            case (r_state)
                MD_IDLE: begin
                    if (bus.startE) begin
                        r_cnt     <= '0;
                        r_isDiv   <= isDivOp(bus.opE);
                        r_negRes  <= w_aNeg ^ w_bNeg;
                        r_negRem  <= w_aNeg;
                        r_divZero <= (bus.srcbE == '0);
                        r_origA   <= bus.srcaE;
                        r_acc     <= '0;
                        r_opnd    <= isDivOp(bus.opE) ? w_aMag : w_bMag;
                        r_mag     <= isDivOp(bus.opE) ? w_bMag : w_aMag;
                    end else begin
                        if (bus.hiwriteE) r_hi <= bus.srcaE;
                        if (bus.lowriteE) r_lo <= bus.srcaE;
                    end
                end
                MD_RUN: begin
                    r_acc  <= w_accNext;
                    r_opnd <= w_opndNext;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_lastIter) begin
                        r_hi <= w_hiRes;
                        r_lo <= w_loRes;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that sits beside the ALU in the execute stage.
- Consumes the forwarded execute-stage operands (srcaE, srcb forwarded value) and produces the HI/LO architectural registers.
- Replaces the single-cycle hi/lo path with a 32-iteration radix-2 engine.
- Exposes a busy signal that the hazard unit uses to stall mfhi/mflo/mult/div issue.

Parameters:
- WIDTH, 32, operand and HI/LO width (only 32 is verified)
- CNTW, 5, iteration counter width, equal to log2(WIDTH)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high; returns unit to IDLE, clears HI/LO
- startE  in  1  launch operation opE this cycle
- opE  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- srcaE  in  WIDTH  rs operand (multiplicand / dividend)
- srcbE  in  WIDTH  rt operand (multiplier / divisor)
- hiwriteE  in  1  mthi: HI <= srcaE
- lowriteE  in  1  mtlo: LO <= srcaE
- busy  out  1  operation in progress (RUN or DONE)
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- States and transitions:
  - IDLE: if startE=1, latch operands, op and sign info, then go to RUN with cnt=0. Otherwise stay.
  - RUN: one radix-2 iteration per cycle. After the iteration at cnt=31, go to DONE; else cnt++.
  - DONE: apply sign fixup, write hi/lo, assert done=1 for this cycle, return to IDLE.
- Latency and timing:
  - startE sampled at edge T.
  - busy=1 from T+1 through T+33.
  - done=1 and new hi/lo visible in cycle T+33 (values registered at the end of RUN).
  - Back-to-back start is accepted in the cycle after DONE.
- busy is a registered output: busy = (state != IDLE).
- startE while busy is ignored. The hazard unit must stall; this unit never queues.
- Multiply:
  - Shift-add on |a|, |b| for signed ops, raw values for unsigned.
  - 64-bit product {hi,lo}; negate the 64-bit result if the signed operand signs differ.
- Divide:
  - Restoring shift-subtract on magnitudes.
  - lo = quotient, hi = remainder.
  - Signed: quotient negated if signs differ; remainder takes the sign of the dividend.
- Divide by zero (srcbE=0): no trap; result is lo=32'hFFFF_FFFF, hi=dividend (original, unsigned bits). The full 32 cycles still elapse.
- Signed overflow (0x8000_0000 / 0xFFFF_FFFF): lo=0x8000_0000, hi=0.
- Width rules: magnitude of 0x8000_0000 is 2^31 as a 32-bit unsigned value; all internal arithmetic is WIDTH+1 bits for the divide subtract and 2*WIDTH bits for the product.
- mthi/mtlo:
  - Applied in IDLE only, one cycle, no done pulse.
  - Ignored while busy; the hazard unit stalls them.
  - hiwriteE and lowriteE may both be set: both registers receive srcaE.
  - If startE and hiwriteE/lowriteE coincide in IDLE, start wins and the write is dropped.
- Reset mid-operation: abort immediately. Next cycle is IDLE, hi=lo=0, no done pulse.
- hi/lo hold their value in all states except the DONE write, mthi/mtlo, and reset.

Decomposition:
- Shared package muldiv_pkg holds:
  - enum muldiv_op_t {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}
  - enum md_state_t {MD_IDLE, MD_RUN, MD_DONE}
  - localparam MD_ITERS = 32
- One natural sub-module, muldiv_step: a combinational single-iteration datapath taking mode, partial accumulator and operand, and returning the next accumulator plus the shifted operand.
- muldiv_unit owns the FSM, counter, sign capture/fixup and HI/LO registers.

Test Plan:
- Reset, then MULTU 0xFFFF_FFFF × 0xFFFF_FFFF at T → busy T+1..T+33, done at T+33, hi=0xFFFF_FFFE, lo=0x0000_0001.
- MULT −3 (0xFFFF_FFFD) × 7 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. Then DIV −7 / 2 started the cycle after DONE → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIVU 100 / 0 → 32-cycle latency unchanged, lo=0xFFFF_FFFF, hi=100. DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- Start DIVU 1000/3, pulse startE again at T+5 with MULTU 2×2 → second start ignored; result lo=333, hi=1, only one done pulse.
- mthi 0x1234 and mtlo 0xABCD in IDLE → hi=0x1234, lo=0xABCD next cycle, no done. Same writes issued while busy → no change.
- Start MULTU 5×5, assert reset at T+10 → next cycle busy=0, hi=lo=0, no done pulse; a new MULTU 5×5 afterwards gives lo=25, hi=0.
